// File: rtl/au_pkg.sv
// au_pkg: shared operation encoding and width helper for the au arithmetic unit
//   Contents: op_e (OP_ADD / OP_MUL), total_width() giving W = WIDTH_1 + WIDTH_2.
package au_pkg;
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } op_e;
  function automatic int total_width(input int width_1, input int width_2);
    return width_1 + width_2;
  endfunction
endpackage

// File: rtl/au_mul.sv
// au_mul: combinational unsigned fixed-point multiplier, product rescaled by >>WIDTH_2
//   Ports: a, b (W-bit operands), q (W-bit truncated scaled product),
//          ovf (scaled product does not fit in W bits).
module au_mul
  import au_pkg::*;
#(
  parameter int WIDTH_1 = 4,
  parameter int WIDTH_2 = 4
) (
  input  logic [total_width(WIDTH_1, WIDTH_2)-1:0] a,
  input  logic [total_width(WIDTH_1, WIDTH_2)-1:0] b,
  output logic [total_width(WIDTH_1, WIDTH_2)-1:0] q,
  output logic                                     ovf
);
  localparam int W = total_width(WIDTH_1, WIDTH_2);
  logic [2*W-1:0] p;
  logic [2*W-1:0] s;
  assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  // Bits shifted in at the top are zero, so any set bit above W-1 means overflow.
  assign s = p >> WIDTH_2;
  assign q = s[W-1:0];
  assign ovf = |s[2*W-1:W];
endmodule

// File: rtl/au.sv
// au: registered unsigned fixed-point add/multiply unit with zero and overflow flags
//   Ports: clk, rst (sync, active-high), in_valid, x_int/x_frac, y_int/y_frac,
//          operation (0 ADD, 1 MUL) -> out_valid, result_int/result_frac, zero, overflow.
//   Build option: define AU_SATURATE_EN to clamp overflowing results to all ones.
module au
  import au_pkg::*;
#(
  parameter int WIDTH_1 = 4,
  parameter int WIDTH_2 = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH_1-1:0] x_int,
  input  logic [WIDTH_2-1:0] x_frac,
  input  logic [WIDTH_1-1:0] y_int,
  input  logic [WIDTH_2-1:0] y_frac,
  input  logic               operation,
  output logic               out_valid,
  output logic [WIDTH_1-1:0] result_int,
  output logic [WIDTH_2-1:0] result_frac,
  output logic               zero,
  output logic               overflow
);
  localparam int W = total_width(WIDTH_1, WIDTH_2);
  logic [W-1:0] x, y, mq, raw, fin;
  logic [W:0]   sum;
  logic         movf, ovf;
  assign x = {x_int, x_frac};
  assign y = {y_int, y_frac};
  assign sum = {1'b0, x} + {1'b0, y};
  au_mul #(.WIDTH_1(WIDTH_1), .WIDTH_2(WIDTH_2)) u_mul (
    .a  (x),
    .b  (y),
    .q  (mq),
    .ovf(movf)
  );
  always_comb begin
    raw = op_e'(operation) == OP_MUL ? mq : sum[W-1:0];
    ovf = op_e'(operation) == OP_MUL ? movf : sum[W];
`ifdef AU_SATURATE_EN
    fin = ovf ? {W{1'b1}} : raw;
`else
    fin = raw;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      result_int  <= '0;
      result_frac <= '0;
      zero        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        {result_int, result_frac} <= fin;
        zero                      <= fin == '0;
        overflow                  <= ovf;
      end
    end
  end
endmodule

// File: tb/tb_au.sv
// tb_au: self-checking bench for au (WIDTH_1=WIDTH_2=4): directed table, reset/stream sequence, random vs model
module tb_au;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] x_int = '0, x_frac = '0, y_int = '0, y_frac = '0;
  logic       operation = 1'b0;
  logic       out_valid;
  logic [3:0] result_int, result_frac;
  logic       zero, overflow;
  int         n_cmp = 0;
  int         n_bad = 0;

  au #(.WIDTH_1(4), .WIDTH_2(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .x_int      (x_int),
    .x_frac     (x_frac),
    .y_int      (y_int),
    .y_frac     (y_frac),
    .operation  (operation),
    .out_valid  (out_valid),
    .result_int (result_int),
    .result_frac(result_frac),
    .zero       (zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       op;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] res;
    logic       ovf;
    logic       zr;
  } vec_t;

  vec_t vecs[8];

  // Reference: plain integer arithmetic on the real values scaled by 16.
  function automatic logic [9:0] model(input logic op, input logic [7:0] x, input logic [7:0] y);
    int v;
    int r;
    logic o;
    v = op ? (int'(x) * int'(y)) / 16 : int'(x) + int'(y);
    o = v > 255;
    r = v % 256;
`ifdef AU_SATURATE_EN
    if (o) r = 255;
`endif
    return {o, r == 0, 8'(r)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic v, input logic [7:0] r, input logic o, input logic z);
    chk({name, " valid"}, int'(out_valid), int'(v));
    chk({name, " result"}, int'({result_int, result_frac}), int'(r));
    chk({name, " ovf"}, int'(overflow), int'(o));
    chk({name, " zero"}, int'(zero), int'(z));
  endtask

  task automatic drive(input logic v, input logic op, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    in_valid  = v;
    operation = op;
    {x_int, x_frac} = x;
    {y_int, y_frac} = y;
  endtask

  initial begin
    logic [9:0] m;
    logic [7:0] er;
    logic       eo, ez, ev;
    vecs[0] = '{"add_55_aa", 1'b0, 8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0};
`ifdef AU_SATURATE_EN
    vecs[1] = '{"add_aa_aa", 1'b0, 8'hAA, 8'hAA, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{"mul_55_aa", 1'b1, 8'h55, 8'hAA, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{"add_ff_01", 1'b0, 8'hFF, 8'h01, 8'hFF, 1'b1, 1'b0};
`else
    vecs[1] = '{"add_aa_aa", 1'b0, 8'hAA, 8'hAA, 8'h54, 1'b1, 1'b0};
    vecs[2] = '{"mul_55_aa", 1'b1, 8'h55, 8'hAA, 8'h87, 1'b1, 1'b0};
    vecs[7] = '{"add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
`endif
    vecs[3] = '{"mul_f0_0f", 1'b1, 8'hF0, 8'h0F, 8'hE1, 1'b0, 1'b0};
    vecs[4] = '{"mul_01_01", 1'b1, 8'h01, 8'h01, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{"mul_00_ff", 1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1};
    vecs[6] = '{"add_00_ff", 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1 chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].x, vecs[i].y);
      @(posedge clk);
      #1 chk_out(vecs[i].name, 1'b1, vecs[i].res, vecs[i].ovf, vecs[i].zr);
    end

    // Idle cycle: valid drops, result and flags hold the last op.
    drive(1'b0, 1'b0, 8'h12, 8'h34);
    @(posedge clk);
    #1 chk_out("hold", 1'b0, vecs[7].res, vecs[7].ovf, vecs[7].zr);

    // Four back-to-back ops, then reset arriving together with a valid op.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].x, vecs[i].y);
      @(posedge clk);
      #1 chk_out({"stream", vecs[i].name}, 1'b1, vecs[i].res, vecs[i].ovf, vecs[i].zr);
    end
    drive(1'b1, 1'b0, 8'h55, 8'hAA);
    rst = 1'b1;
    @(posedge clk);
    #1 chk_out("rst_mid", 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk_out("post_rst", 1'b0, 8'h00, 1'b0, 1'b0);

    er = 8'h00; eo = 1'b0; ez = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic       v, op, r;
      logic [7:0] x, y;
      v  = 1'($urandom_range(0, 3) != 0);
      op = 1'($urandom);
      x  = 8'($urandom);
      y  = 8'($urandom);
      if (i % 5 == 0) x = {4'($urandom), 4'h0};
      r  = 1'($urandom_range(0, 40) == 0);
      drive(v, op, x, y);
      rst = r;
      @(posedge clk);
      if (r) begin
        er = 8'h00; eo = 1'b0; ez = 1'b0; ev = 1'b0;
      end else begin
        ev = v;
        if (v) begin
          m  = model(op, x, y);
          eo = m[9]; ez = m[8]; er = m[7:0];
        end
      end
      #1 chk_out("random", ev, er, eo, ez);
    end

    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
